// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : Decode-stage register scoreboard. Tracks every in-flight register
//            write with a busy bit and, when forwarding is built in, a
//            bypass-readiness countdown. Produces the decode stall, the issue
//            strobe and per-operand forward-select flags.
// Options  : HAZARD_SCOREBOARD_FWD_EN
//              defined     -> countdown-based forwarding. A consumer issues
//                             from the bypass network as soon as the
//                             producer's latency has elapsed.
//              not defined -> no countdown storage. RAW hazards stall until
//                             writeback, fwd outputs are tied 0 and dec_lat
//                             is ignored.
// Ports    : clk, rst          clock, asynchronous active-high reset
//            dec_valid         decode holds a valid instruction
//            dec_rs1/rs2/rd    operand / destination register indices
//            dec_use_rs1/rs2   instruction reads that source
//            dec_wr_rd         instruction writes rd
//            dec_lat           producer latency before result is forwardable
//            exe_ready         downstream accepts an instruction this cycle
//            wb_valid, wb_rd   writeback commit of a register
//            stall_out         valid instruction blocked by a hazard
//            issue_out         valid instruction leaves decode this cycle
//            fwd1_out/fwd2_out source taken from bypass (valid with issue)
//            busy_vec_out      current busy bits (bit 0 always 0)
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int REG_FILE_LEN = 32,
    parameter int MAX_LAT      = 7,
    parameter int LAT_W        = $clog2(MAX_LAT + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            dec_valid,
    input  logic [$clog2(REG_FILE_LEN)-1:0] dec_rs1,
    input  logic [$clog2(REG_FILE_LEN)-1:0] dec_rs2,
    input  logic [$clog2(REG_FILE_LEN)-1:0] dec_rd,
    input  logic                            dec_use_rs1,
    input  logic                            dec_use_rs2,
    input  logic                            dec_wr_rd,
    input  logic [LAT_W-1:0]                dec_lat,
    input  logic                            exe_ready,
    input  logic                            wb_valid,
    input  logic [$clog2(REG_FILE_LEN)-1:0] wb_rd,
    output logic                            stall_out,
    output logic                            issue_out,
    output logic                            fwd1_out,
    output logic                            fwd2_out,
    output logic [REG_FILE_LEN-1:0]         busy_vec_out
);

    localparam int C_IDX_W = $clog2(REG_FILE_LEN);

    logic [REG_FILE_LEN-1:0] r_busy;
    logic [REG_FILE_LEN-1:0] w_busy_nxt;
    logic [REG_FILE_LEN-1:0] w_wb_mask;
    logic [REG_FILE_LEN-1:0] w_eb;

    logic w_rs1_live;
    logic w_rs2_live;
    logic w_rs1_haz;
    logic w_rs2_haz;
    logic w_waw;
    logic w_hazard;
    logic w_load;

    // ------------------------------------------------------------------
    // Effective busy: a register committing this cycle already reads as
    // free, so a consumer waiting on it can issue in the writeback cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_wb_mask = '0;
        if (wb_valid) begin
            w_wb_mask[wb_rd] = 1'b1;
        end
    end

    assign w_eb = r_busy & ~w_wb_mask;

    // A source is "live" when it is read, nonzero and still owned by an
    // in-flight producer.
    assign w_rs1_live = dec_use_rs1 & (dec_rs1 != C_IDX_W'(0)) & w_eb[dec_rs1];
    assign w_rs2_live = dec_use_rs2 & (dec_rs2 != C_IDX_W'(0)) & w_eb[dec_rs2];

    // WAW always stalls, so an issuing write never targets a busy register.
    assign w_waw = dec_wr_rd & (dec_rd != C_IDX_W'(0)) & w_eb[dec_rd];

    assign w_hazard  = w_rs1_haz | w_rs2_haz | w_waw;
    assign stall_out = dec_valid & w_hazard;
    assign issue_out = dec_valid & ~w_hazard & exe_ready;
    assign w_load    = issue_out & dec_wr_rd & (dec_rd != C_IDX_W'(0));

    // ------------------------------------------------------------------
    // Busy bits: writeback clears, issue sets; the issue is applied last
    // so it wins on a same-register collision. Register 0 never tracks.
    // ------------------------------------------------------------------
    always_comb begin
        w_busy_nxt = r_busy;
        if (wb_valid) begin
            w_busy_nxt[wb_rd] = 1'b0;
        end
        if (w_load) begin
            w_busy_nxt[dec_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign busy_vec_out = r_busy;

`ifdef HAZARD_SCOREBOARD_FWD_EN
    // ------------------------------------------------------------------
    // Bypass-readiness countdown. A source whose producer is still busy
    // but whose count has reached zero is available on the bypass network.
    // ------------------------------------------------------------------
    localparam logic [LAT_W-1:0] C_MAX_LAT = LAT_W'(MAX_LAT);

    logic [LAT_W-1:0] r_cnt     [REG_FILE_LEN];
    logic [LAT_W-1:0] w_cnt_nxt [REG_FILE_LEN];
    logic [LAT_W-1:0] w_lat;

    // Out-of-range latencies are clamped rather than trusted.
    assign w_lat = (dec_lat > C_MAX_LAT) ? C_MAX_LAT : dec_lat;

    assign w_rs1_haz = w_rs1_live & (r_cnt[dec_rs1] != LAT_W'(0));
    assign w_rs2_haz = w_rs2_live & (r_cnt[dec_rs2] != LAT_W'(0));
    assign fwd1_out  = w_rs1_live & (r_cnt[dec_rs1] == LAT_W'(0));
    assign fwd2_out  = w_rs2_live & (r_cnt[dec_rs2] == LAT_W'(0));

    always_comb begin
        for (int i = 0; i < REG_FILE_LEN; i++) begin
            w_cnt_nxt[i] = (r_cnt[i] != LAT_W'(0)) ? (r_cnt[i] - LAT_W'(1)) : LAT_W'(0);
        end
        if (wb_valid) begin
            w_cnt_nxt[wb_rd] = '0;
        end
        // A freshly loaded entry is not decremented in its load cycle.
        if (w_load) begin
            w_cnt_nxt[dec_rd] = w_lat;
        end
        w_cnt_nxt[0] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_FILE_LEN; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end
`else
    // Without forwarding a RAW dependency simply waits for writeback and
    // the producer latency carries no information.
    logic w_unused_lat;

    assign w_unused_lat = ^dec_lat;
    assign w_rs1_haz    = w_rs1_live;
    assign w_rs2_haz    = w_rs2_live;
    assign fwd1_out     = 1'b0;
    assign fwd2_out     = 1'b0;
`endif

endmodule
`default_nettype wire
